complex_mult_axis: RTL and testbench

COMPLEX_MULT_AXIS -- requirements
Module: complex_mult_axis

---
 rtl/axis_pkg.sv | 36 +++
 rtl/pipe_ctrl.sv | 42 ++++
 rtl/complex_mult_axis.sv | 122 ++++++++++++
 tb/tb_complex_mult_axis.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and the rounding/saturation helper for the complex multiplier.
// Widths are carried at a fixed accumulator width; callers pass the real shift/output width.
package axis_pkg;

    localparam int ACC_W = 64;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        acc_t re;
        acc_t im;
    } cplx_t;

    typedef struct packed {
        logic ovf;
        acc_t val;
    } sat_t;

    // Round half up (when shift > 0), arithmetic shift, then clamp to out_w signed range.
    function automatic sat_t round_sat(input acc_t x, input int unsigned shift,
                                       input int unsigned out_w);
        acc_t r;
        acc_t maxv;
        acc_t minv;
        sat_t s;
        r = x;
        if (shift > 0) r = x + (acc_t'(1) <<< (shift - 1));
        r = r >>> shift;
        maxv = (acc_t'(1) <<< (out_w - 1)) - acc_t'(1);
        minv = ~maxv;
        s.ovf = (r > maxv) || (r < minv);
        s.val = (r > maxv) ? maxv : ((r < minv) ? minv : r);
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Per-stage valid bits and load enables for an elastic pipeline of PIPE_NUM stages.
// A stage loads when it is empty or the stage after it advances, so bubbles collapse.
module pipe_ctrl #(
    parameter int PIPE_NUM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                m_ready,
    output logic                m_valid,
    output logic [PIPE_NUM-1:0] en
);

    logic [PIPE_NUM-1:0] vld_d, vld_q;
    logic                blocked;

    always_comb begin
        en      = '0;
        vld_d   = vld_q;
        blocked = 1'b0;
        // Stage i is stuck only if it and every stage downstream are full and output stalls.
        for (int i = 0; i < PIPE_NUM; i++) begin
            blocked = !m_ready;
            for (int j = i; j < PIPE_NUM; j++) blocked = blocked && vld_q[j];
            en[i] = !blocked;
        end
        if (en[0]) vld_d[0] = s_valid;
        for (int i = 1; i < PIPE_NUM; i++) begin
            if (en[i]) vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign s_ready = en[0] && !rst;
    assign m_valid = vld_q[PIPE_NUM-1];

endmodule

// File: rtl/complex_mult_axis.sv
// Streaming complex multiplier (a*b or a*conj(b)) with rounding, saturation and backpressure.
// Stage 0 holds the four partial products, stage 1 the rounded result, later stages delay it.
module complex_mult_axis
    import axis_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 15,
    parameter int PIPE_NUM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [2*DATA_W-1:0] s_a,
    input  logic [2*COEF_W-1:0] s_b,
    input  logic                s_conj,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*OUT_W-1:0]  m_z,
    output logic                m_last,
    output logic                m_ovf
);

    localparam int PW = DATA_W + COEF_W;
    localparam int SW = PW + 1;

    typedef struct packed {
        logic signed [PW-1:0] rr;
        logic signed [PW-1:0] ii;
        logic signed [PW-1:0] ri;
        logic signed [PW-1:0] ir;
        logic                 conj;
        logic                 last;
    } prod_t;

    typedef struct packed {
        logic [2*OUT_W-1:0] z;
        logic               ovf;
        logic               last;
    } res_t;

    logic [PIPE_NUM-1:0] en;

    pipe_ctrl #(.PIPE_NUM(PIPE_NUM)) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .en      (en)
    );

    logic signed [DATA_W-1:0] a_re, a_im;
    logic signed [COEF_W-1:0] b_re, b_im;

    assign a_re = s_a[DATA_W-1:0];
    assign a_im = s_a[2*DATA_W-1:DATA_W];
    assign b_re = s_b[COEF_W-1:0];
    assign b_im = s_b[2*COEF_W-1:COEF_W];

    prod_t                 prod_d, prod_q;
    res_t [PIPE_NUM-1:1]   res_d, res_q;
    logic signed [SW-1:0]  sum_re, sum_im;
    cplx_t                 acc;
    sat_t                  sat_re, sat_im;

    always_comb begin
        prod_d = prod_q;
        if (en[0]) begin
            prod_d.rr   = PW'(a_re) * PW'(b_re);
            prod_d.ii   = PW'(a_im) * PW'(b_im);
            prod_d.ri   = PW'(a_re) * PW'(b_im);
            prod_d.ir   = PW'(a_im) * PW'(b_re);
            prod_d.conj = s_conj;
            prod_d.last = s_last;
        end
    end

    always_comb begin
        // One guard bit over the product width keeps the sum exact.
        if (prod_q.conj) begin
            sum_re = SW'($signed(prod_q.rr)) + SW'($signed(prod_q.ii));
            sum_im = SW'($signed(prod_q.ir)) - SW'($signed(prod_q.ri));
        end else begin
            sum_re = SW'($signed(prod_q.rr)) - SW'($signed(prod_q.ii));
            sum_im = SW'($signed(prod_q.ri)) + SW'($signed(prod_q.ir));
        end
        acc.re = ACC_W'(sum_re);
        acc.im = ACC_W'(sum_im);
        sat_re = round_sat(acc.re, SHIFT, OUT_W);
        sat_im = round_sat(acc.im, SHIFT, OUT_W);

        res_d = res_q;
        if (en[1]) begin
            res_d[1].z    = {sat_im.val[OUT_W-1:0], sat_re.val[OUT_W-1:0]};
            res_d[1].ovf  = sat_re.ovf || sat_im.ovf;
            res_d[1].last = prod_q.last;
        end
        for (int i = 2; i < PIPE_NUM; i++) begin
            if (en[i]) res_d[i] = res_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            res_q  <= '0;
        end else begin
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

    assign m_z    = res_q[PIPE_NUM-1].z;
    assign m_ovf  = res_q[PIPE_NUM-1].ovf;
    assign m_last = res_q[PIPE_NUM-1].last;

endmodule

// File: tb/tb_complex_mult_axis.sv
// Bench for complex_mult_axis: directed table, backpressure/reset sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_complex_mult_axis;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int OW = 16;
    localparam int SH = 15;
    localparam int PN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_conj, s_last;
    logic [31:0] s_a, s_b;
    logic        m_valid, m_ready, m_last, m_ovf;
    logic [31:0] m_z;

    complex_mult_axis #(
        .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(SH), .PIPE_NUM(PN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_conj  (s_conj),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_z     (m_z),
        .m_last  (m_last),
        .m_ovf   (m_ovf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] z;
        bit          ovf;
        bit          last;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        int ar, ai, br, bi;
        bit conj;
        int ere, eim;
        bit eovf;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic longint scale(input longint x, inout bit ovf);
        longint y;
        y = (x + (longint'(1) << (SH - 1))) >>> SH;
        if (y > 32767) begin
            y = 32767;
            ovf = 1'b1;
        end else if (y < -32768) begin
            y = -32768;
            ovf = 1'b1;
        end
        return y;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit cj, input bit lst);
        longint ar, ai, br, bi, re, im;
        exp_t e;
        ar = longint'($signed(a[15:0]));
        ai = longint'($signed(a[31:16]));
        br = longint'($signed(b[15:0]));
        bi = longint'($signed(b[31:16]));
        re = cj ? ar * br + ai * bi : ar * br - ai * bi;
        im = cj ? ai * br - ar * bi : ar * bi + ai * br;
        e.ovf  = 1'b0;
        re     = scale(re, e.ovf);
        im     = scale(im, e.ovf);
        e.z    = {16'(im), 16'(re)};
        e.last = lst;
        return e;
    endfunction

    // Scoreboard and stall-hold monitor, sampled mid-cycle.
    bit          prev_stall = 1'b0;
    logic [33:0] prev_out;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_valid) chk("stall_hold", {m_z, m_ovf, m_last}, prev_out);
            if (s_valid && s_ready) exp_q.push_back(model(s_a, s_b, s_conj, s_last));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {m_z, m_ovf, m_last}, {mon_e.z, mon_e.ovf, mon_e.last});
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_z, m_ovf, m_last};
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int g;
        int lat;
        @(posedge clk); #1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_a     = {16'(v.ai), 16'(v.ar)};
        s_b     = {16'(v.bi), 16'(v.br)};
        s_conj  = v.conj;
        s_last  = idx[0];
        g = 0;
        @(negedge clk);
        while (!s_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 20);
        chk($sformatf("vec%0d_latency", idx), lat, PN);
        chk($sformatf("vec%0d_re", idx), longint'($signed(m_z[15:0])), v.ere);
        chk($sformatf("vec%0d_im", idx), longint'($signed(m_z[31:16])), v.eim);
        chk($sformatf("vec%0d_ovf", idx), m_ovf, v.eovf);
    endtask

    task automatic drain();
        int g;
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        g = 0;
        while (exp_q.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl[12];
        int   acc;
        int   mv;
        int   k;
        tbl[0]  = '{16384, 0, 16384, 0, 1'b0, 8192, 0, 1'b0};
        tbl[1]  = '{0, 16384, 0, 16384, 1'b0, -8192, 0, 1'b0};
        tbl[2]  = '{0, 16384, 0, 16384, 1'b1, 8192, 0, 1'b0};
        tbl[3]  = '{3, 0, 16384, 0, 1'b0, 2, 0, 1'b0};
        tbl[4]  = '{-3, 0, 16384, 0, 1'b0, -1, 0, 1'b0};
        tbl[5]  = '{-32768, 0, -32768, 0, 1'b0, 32767, 0, 1'b1};
        tbl[6]  = '{-32768, -32768, -32768, -32768, 1'b1, 32767, 0, 1'b1};
        tbl[7]  = '{-32768, -32768, 32767, 32767, 1'b1, -32768, 0, 1'b1};
        tbl[8]  = '{-32768, 0, 32767, 0, 1'b0, -32767, 0, 1'b0};
        tbl[9]  = '{32767, 32767, 32767, -32768, 1'b0, 32767, -1, 1'b1};
        tbl[10] = '{1, 0, 16384, 0, 1'b0, 1, 0, 1'b0};
        tbl[11] = '{-1, 0, 16384, 0, 1'b0, 0, 0, 1'b0};

        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_conj = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_z", m_z, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_m_valid", m_valid, 0);
        chk("post_rst_s_ready", s_ready, 1);

        foreach (tbl[i]) run_vec(tbl[i], i);
        drain();

        // Backpressure: output stalled for 10 cycles with continuous input.
        m_ready = 1'b0;
        acc = 0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_a     = {16'd0, 16'(k * 1000 + 7)};
            s_b     = {16'd0, 16'd32767};
            s_conj  = 1'b0;
            s_last  = (k % 3 == 2);
            @(negedge clk);
            if (s_ready) begin
                acc++;
                k++;
            end
        end
        chk("bp_accepts", acc, PN);
        chk("bp_s_ready_low", s_ready, 0);
        chk("bp_m_valid", m_valid, 1);
        drain();

        // Full throughput with both sides always ready.
        acc = 0;
        mv = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_a = $urandom;
            s_b = $urandom;
            s_conj = 1'($urandom);
            s_last = 1'($urandom);
            @(negedge clk);
            if (s_ready) acc++;
            if (c >= PN && m_valid) mv++;
        end
        chk("tput_accepts", acc, 20);
        chk("tput_outputs", mv, 20 - PN);
        drain();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            s_valid = ($urandom_range(0, 3) != 0);
            s_a = $urandom;
            s_b = $urandom;
            s_conj = 1'($urandom);
            s_last = 1'($urandom);
            m_ready = ($urandom_range(0, 2) != 0);
        end
        drain();

        // Reset with three beats in flight.
        m_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_a = {16'd5, 16'(1000 + b)};
            s_b = {16'd0, 16'd16384};
            s_conj = 1'b0;
            s_last = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("inflight_m_valid_before", m_valid, 1);
        chk("inflight_rst_s_ready", s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("inflight_m_valid_after", m_valid, 0);
        chk("inflight_m_z_after", m_z, 0);
        chk("inflight_flags_after", {m_last, m_ovf}, 0);
        m_ready = 1'b1;
        mv = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) mv++;
        end
        chk("inflight_no_stale", mv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
